led_scan_controller: RTL

Time-multiplexing scheduler for the bicycle computer's common-cathode LED display. It takes a packed set of 4-bit digit codes and decimal-point flags from the mode/datapath logic and drives the shared SegA–SegG/DP lines and per-digit nDigit enables. Each digit gets one slot per frame, with a blanking guard before it is enabled to prevent ghosting. New display data is double-buffered so that a frame never mixes old and new values.

---
 rtl/led_scan_controller.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/led_scan_controller.sv
// ---------------------------------------------------------------------------
// led_scan_controller
//
// Time-multiplexed scan driver for a common-cathode multi-digit LED display.
// Each digit owns one slot per frame: BLANK_CYCLES with every digit disabled
// (anti-ghosting guard), then ON_CYCLES with its cathode enabled and its
// segments driven. Display data is double-buffered: a Load lands in pending
// registers and is promoted to the active registers only at a frame boundary,
// so a frame never mixes old and new values.
//
// Parameters:
//   NUM_DIGITS   - number of digits (>= 1)
//   ON_CYCLES    - enabled cycles per slot (>= 1)
//   BLANK_CYCLES - blanked cycles per slot before enable (>= 1)
//
// Ports:
//   Clock       in   system clock
//   nReset      in   asynchronous active-low reset
//   DigitCode   in   4 bits per digit, digit 0 rightmost at [3:0]
//   DpMask      in   decimal point request per digit
//   Load        in   strobe capturing DigitCode/DpMask
//   LeadBlank   in   leading-zero suppression enable, sampled at slot start
//   SegA..SegG  out  segment drives, active high
//   DP          out  decimal point drive, active high
//   nDigit      out  digit enables, active low, at most one low
//   FrameStart  out  one-cycle pulse in the first cycle of slot 0 (not for
//                    the first frame after reset)
// ---------------------------------------------------------------------------
module led_scan_controller #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned ON_CYCLES    = 28,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic                    Clock,
    input  logic                    nReset,
    input  logic [4*NUM_DIGITS-1:0] DigitCode,
    input  logic [NUM_DIGITS-1:0]   DpMask,
    input  logic                    Load,
    input  logic                    LeadBlank,
    output logic                    SegA,
    output logic                    SegB,
    output logic                    SegC,
    output logic                    SegD,
    output logic                    SegE,
    output logic                    SegF,
    output logic                    SegG,
    output logic                    DP,
    output logic [NUM_DIGITS-1:0]   nDigit,
    output logic                    FrameStart
);

    localparam int unsigned MAXC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int unsigned IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    // Scheduler
    logic [0:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fs_q, fs_d;
    logic          lb_q, lb_d;

    // Display buffers
    logic [4*NUM_DIGITS-1:0] act_code_q, act_code_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_code_q, pend_code_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pending_q, pending_d;

    // Output registers
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] ndig_q, ndig_d;

    // Suppression / selection helpers
    logic [NUM_DIGITS-1:0] supp;
    logic                  sup_run;
    logic [3:0]            cur_code;
    logic                  cur_dp;
    logic                  cur_sup;

    // Segment pattern as {A,B,C,D,E,F,G}
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        case (code)
            4'h0:    seg_decode = 7'b1111110;
            4'h1:    seg_decode = 7'b0110000;
            4'h2:    seg_decode = 7'b1101101;
            4'h3:    seg_decode = 7'b1111001;
            4'h4:    seg_decode = 7'b0110011;
            4'h5:    seg_decode = 7'b1011011;
            4'h6:    seg_decode = 7'b1011111;
            4'h7:    seg_decode = 7'b1110000;
            4'h8:    seg_decode = 7'b1111111;
            4'h9:    seg_decode = 7'b1111011;
            4'hA:    seg_decode = 7'b0000001;
            4'hE:    seg_decode = 7'b1001111;
            default: seg_decode = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 1'b1;
        fs_d    = 1'b0;
        if (state_q == ST_BLANK) begin
            if (cnt_q == BLANK_LAST) begin
                state_d = ST_ON;
                cnt_d   = '0;
            end
        end else begin
            if (cnt_q == ON_LAST) begin
                state_d = ST_BLANK;
                cnt_d   = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                    fs_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
    end

    // LeadBlank is latched in the first cycle of every slot.
    assign lb_d = (state_q == ST_BLANK && cnt_q == '0) ? LeadBlank : lb_q;

    // fs_q is high exactly in the first cycle of slot 0 BLANK that was reached
    // by wrapping, so it doubles as the frame-boundary qualifier.
    always_comb begin
        act_code_d  = act_code_q;
        act_dp_d    = act_dp_q;
        pend_code_d = pend_code_q;
        pend_dp_d   = pend_dp_q;
        pending_d   = pending_q;
        if (fs_q) begin
            pending_d = 1'b0;
            if (Load) begin
                act_code_d = DigitCode;
                act_dp_d   = DpMask;
            end else if (pending_q) begin
                act_code_d = pend_code_q;
                act_dp_d   = pend_dp_q;
            end
        end else if (Load) begin
            pend_code_d = DigitCode;
            pend_dp_d   = DpMask;
            pending_d   = 1'b1;
        end
    end

    // Walk from the most significant digit down; a digit is suppressible while
    // it and all digits above it are zero with no DP set.
    always_comb begin
        supp    = '0;
        sup_run = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            sup_run = sup_run & (act_code_d[4*(NUM_DIGITS-1-k) +: 4] == 4'h0)
                              & ~act_dp_d[NUM_DIGITS-1-k];
            supp[NUM_DIGITS-1-k] = sup_run & (k != NUM_DIGITS - 1);
        end
    end

    // Outputs are computed from next-state values so the registered outputs
    // line up with the scheduler state of the same cycle.
    always_comb begin
        cur_code = 4'hF;
        cur_dp   = 1'b0;
        cur_sup  = 1'b0;
        ndig_d   = '1;
        seg_d    = '0;
        dp_d     = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                cur_code = act_code_d[4*i +: 4];
                cur_dp   = act_dp_d[i];
                cur_sup  = supp[i];
            end
        end
        if (state_d == ST_ON) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                ndig_d[i] = (idx_d != IW'(i));
            end
            if (!(lb_d && cur_sup)) begin
                seg_d = seg_decode(cur_code);
                dp_d  = cur_dp;
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_BLANK;
            idx_q       <= '0;
            cnt_q       <= '0;
            fs_q        <= 1'b0;
            lb_q        <= 1'b0;
            act_code_q  <= '1;
            act_dp_q    <= '0;
            pend_code_q <= '0;
            pend_dp_q   <= '0;
            pending_q   <= 1'b0;
            seg_q       <= '0;
            dp_q        <= 1'b0;
            ndig_q      <= '1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            fs_q        <= fs_d;
            lb_q        <= lb_d;
            act_code_q  <= act_code_d;
            act_dp_q    <= act_dp_d;
            pend_code_q <= pend_code_d;
            pend_dp_q   <= pend_dp_d;
            pending_q   <= pending_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            ndig_q      <= ndig_d;
        end
    end

    assign SegA       = seg_q[6];
    assign SegB       = seg_q[5];
    assign SegC       = seg_q[4];
    assign SegD       = seg_q[3];
    assign SegE       = seg_q[2];
    assign SegF       = seg_q[1];
    assign SegG       = seg_q[0];
    assign DP         = dp_q;
    assign nDigit     = ndig_q;
    assign FrameStart = fs_q;

endmodule
